// File: rtl/instr_seq_pkg.sv
// Instruction sequencer shared definitions:
// opcode encodings and controller states.
package instr_seq_pkg;

    localparam logic [2:0] MV  = 3'b000;
    localparam logic [2:0] MVI = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b011;
    localparam logic [2:0] MVO = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        IMM,
        WAIT,
        ERR
    } seq_state_e;

    function automatic logic is_mvi(input logic [2:0] op);
        return op == MVI;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy count.
// Read data is the current head word, valid whenever empty is low.
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + (AW+1)'(1);
            else if (!do_push && do_pop)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_sequencer.sv
// Feeds queued instructions to a processor one at a time,
// handling MVI immediates, single-stepping and completion timeout.
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              step_mode,
    input  logic              step,
    input  logic              done,
    input  logic [DATA_W-1:0] dout,
    output logic              run,
    output logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              err_timeout,
    output logic [CNT_W-1:0]  instr_count,
    output logic [DATA_W-1:0] last_dout
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    seq_state_e        state;
    seq_state_e        state_nxt;
    logic              run_nxt;
    logic [DATA_W-1:0] din_nxt;
    logic [DATA_W-1:0] last_nxt;
    logic              err_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_nxt;

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic [AW:0]       count;
    logic              head_mvi;
    logic              can_launch;

    assign in_ready = !full && state != ERR;
    assign push     = in_valid && in_ready;
    assign busy     = state != IDLE;
    assign head_mvi = is_mvi(head[DATA_W-1 -: 3]);

    // An MVI needs its immediate already stored before it may launch.
    assign can_launch = (!step_mode || step) &&
                        (head_mvi ? count >= (AW+1)'(2) : !empty);

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        din_nxt   = din;
        last_nxt  = last_dout;
        err_nxt   = err_timeout;
        cnt_nxt   = instr_count;
        timer_nxt = timer;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (can_launch) begin
                    din_nxt   = head;
                    run_nxt   = 1'b1;
                    pop       = 1'b1;
                    timer_nxt = '0;
                    state_nxt = head_mvi ? IMM : WAIT;
                end
            end
            IMM: begin
                din_nxt   = head;
                pop       = 1'b1;
                timer_nxt = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (done) begin
                    run_nxt   = 1'b0;
                    din_nxt   = '0;
                    last_nxt  = dout;
                    cnt_nxt   = instr_count + CNT_W'(1);
                    state_nxt = IDLE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    run_nxt   = 1'b0;
                    din_nxt   = '0;
                    err_nxt   = 1'b1;
                    state_nxt = ERR;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            run         <= 1'b0;
            din         <= '0;
            last_dout   <= '0;
            err_timeout <= 1'b0;
            instr_count <= '0;
            timer       <= '0;
        end else begin
            state       <= state_nxt;
            run         <= run_nxt;
            din         <= din_nxt;
            last_dout   <= last_nxt;
            err_timeout <= err_nxt;
            instr_count <= cnt_nxt;
            timer       <= timer_nxt;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: issued words and
// completions are checked by a monitor against a queue model.
module tb_instr_sequencer;
    import instr_seq_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int TMO   = 64;
    localparam int CW    = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          step_mode;
    logic          step;
    logic          done = 1'b0;
    logic [DW-1:0] dout = '0;
    logic          run;
    logic [DW-1:0] din;
    logic          busy;
    logic          err_timeout;
    logic [CW-1:0] instr_count;
    logic [DW-1:0] last_dout;

    always #5 clock = ~clock;

    instr_sequencer #(
        .DATA_W  (DW),
        .DEPTH   (DEPTH),
        .TIMEOUT (TMO),
        .CNT_W   (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .step_mode   (step_mode),
        .step        (step),
        .done        (done),
        .dout        (dout),
        .run         (run),
        .din         (din),
        .busy        (busy),
        .err_timeout (err_timeout),
        .instr_count (instr_count),
        .last_dout   (last_dout)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: every accepted word, in order; issue pointer advanced
    // by the monitor as words appear on din.
    logic [DW-1:0] exp_mem [4096];
    int            pushed_total = 0;
    int            issued_total = 0;
    bit            err_exp = 1'b0;

    // 0 random latency, 1 fixed latency/dout, 2 never done, 3 done always
    int            done_mode = 0;
    int            man_lat = 0;
    logic [DW-1:0] man_dout = '0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } comp_t;

    comp_t         cq[$];
    comp_t         e;
    logic [CW-1:0] exp_cnt = '0;
    bit            prev_run = 1'b0;
    bit            imm_pend = 1'b0;
    int            cd = -1;

    // Monitor and processor responder.
    always @(negedge clock) begin
        if (reset) begin
            prev_run     = 1'b0;
            imm_pend     = 1'b0;
            cd           = -1;
            cq.delete();
            exp_cnt      = '0;
            issued_total = 0;
            done         = 1'b0;
        end else begin
            if (imm_pend || (run && !prev_run)) begin
                if (issued_total >= pushed_total) begin
                    total++;
                    bad++;
                    $display("FAIL issue: unexpected word din=%h", din);
                end else begin
                    chk(imm_pend ? "imm_din" : "launch_din", din,
                        exp_mem[issued_total]);
                    issued_total++;
                end
                if (!imm_pend && din[DW-1 -: 3] == MVI) begin
                    imm_pend = 1'b1;
                end else begin
                    imm_pend = 1'b0;
                    if (done_mode == 0)
                        cd = $urandom_range(0, 4);
                    else if (done_mode == 1)
                        cd = man_lat;
                    else
                        cd = -1;
                end
            end
            if (!run && prev_run) begin
                if (done_mode == 2) begin
                    chk("timeout_flag", err_timeout, 1);
                    chk("timeout_din", din, 0);
                end else if (cq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL run_drop: run fell with no done given");
                end else begin
                    e = cq.pop_front();
                    chk("last_dout", last_dout, e.d);
                    chk("instr_count", instr_count, e.c);
                    chk("din_cleared", din, 0);
                    chk("no_err", err_timeout, 0);
                end
            end
            done = (done_mode == 3);
            if (cd == 0) begin
                done = 1'b1;
                dout = (done_mode == 1) ? man_dout : DW'($urandom);
                exp_cnt++;
                e.d = dout;
                e.c = exp_cnt;
                cq.push_back(e);
                cd = -1;
            end else if (cd > 0) begin
                cd--;
            end
            prev_run = run;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        bit exp_rdy;
        exp_rdy = (pushed_total - issued_total < DEPTH) && !err_exp;
        in_valid = 1'b1;
        in_data  = w;
        chk("in_ready", in_ready, exp_rdy);
        if (exp_rdy) begin
            exp_mem[pushed_total] = w;
            pushed_total++;
        end
        cyc(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || issued_total != pushed_total) && n < budget) begin
            if (!busy && pushed_total - issued_total == 1 && !step_mode &&
                exp_mem[issued_total][DW-1 -: 3] == MVI)
                push(16'h0000);
            else
                cyc(1);
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL wait_idle: budget expired busy=%0b pending=%0d",
                     busy, pushed_total - issued_total);
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        pushed_total = 0;
        err_exp      = 1'b0;
        cyc(1);
        chk("rst_run", run, 0);
        chk("rst_din", din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_last", last_dout, 0);
        chk("rst_ready", in_ready, 1);
        reset = 1'b0;
        cyc(1);
    endtask

    function automatic logic [DW-1:0] non_mvi_word();
        logic [2:0] op;
        op = 3'($urandom_range(0, 3));
        if (op == MVI)
            op = MVO;
        return {op, 13'($urandom)};
    endfunction

    int hi;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        step_mode = 1'b0;
        step      = 1'b0;
        cyc(2);
        do_reset();

        // MVI with immediate, fixed latency
        done_mode = 1;
        man_lat   = 1;
        man_dout  = 16'h5A5A;
        push(16'h2000);
        push(16'h1234);
        wait_idle(50);
        chk("mvi_count", instr_count, 1);

        // no same-cycle bypass from push to issue
        done_mode = 0;
        push(16'h0042);
        chk("no_bypass", run, 0);
        cyc(1);
        chk("launch_next", run, 1);
        wait_idle(50);

        // fill to DEPTH while held by step mode
        step_mode = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            push(non_mvi_word());
        chk("full_ready", in_ready, 0);
        push(16'hFFFF);
        step_mode = 1'b0;
        push(16'h7777);
        push(16'h4444);
        wait_idle(400);

        // single stepping; step while busy is not queued
        step_mode = 1'b1;
        push(16'h4001);
        push(16'h6001);
        cyc(3);
        chk("step_hold", busy, 0);
        done_mode = 1;
        man_lat   = 3;
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        chk("step1_run", run, 1);
        chk("step1_din", din, 16'h4001);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        for (int i = 0; i < 20 && busy; i++)
            cyc(1);
        cyc(3);
        chk("step_not_queued", busy, 0);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        chk("step2_din", din, 16'h6001);
        step_mode = 1'b0;
        wait_idle(50);

        // MVI header alone must hold, even with a step pulse
        man_lat   = 0;
        man_dout  = 16'hBEEF;
        push(16'h2000);
        step_mode = 1'b1;
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        step_mode = 1'b0;
        cyc(3);
        chk("mvi_hold_busy", busy, 0);
        chk("mvi_hold_run", run, 0);
        push(16'h0BEE);
        wait_idle(50);
        chk("last_dout_beef", last_dout, 16'hBEEF);

        // done outside WAIT is ignored
        done_mode = 3;
        cyc(3);
        done_mode = 0;
        cyc(1);
        chk("spurious_done_cnt", instr_count, exp_cnt);
        chk("spurious_done_busy", busy, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0)
                step_mode = !step_mode;
            step = step_mode && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) != 0)
                push(DW'($urandom));
            else
                cyc(1);
        end
        step = 1'b0;
        step_mode = 1'b0;
        wait_idle(2000);

        // timeout into terminal error state
        done_mode = 2;
        push(16'h0001);
        hi = 0;
        for (int i = 0; i < TMO + 16; i++) begin
            if (run)
                hi++;
            cyc(1);
        end
        chk("timeout_run_cycles", hi, TMO);
        chk("timeout_err", err_timeout, 1);
        chk("timeout_busy", busy, 1);
        err_exp = 1'b1;
        push(16'h0002);
        chk("err_run", run, 0);
        do_reset();

        // reset in WAIT with three words queued
        push(16'h4001);
        push(16'h6002);
        push(16'h8003);
        push(16'h0004);
        cyc(2);
        chk("wait_busy", busy, 1);
        chk("wait_run", run, 1);
        do_reset();
        done_mode = 0;
        cyc(4);
        chk("flushed_busy", busy, 0);
        chk("flushed_run", run, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
